// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: controller states and the MM:SS field limit.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_RUN    = 2'd1,
    ST_ADJUST = 2'd2
  } state_e;

  localparam logic [5:0] MAX_FIELD = 6'd59;

  // Wrapping +1 on a 0..59 field; never produces a value above MAX_FIELD.
  function automatic logic [5:0] inc_field(input logic [5:0] v);
    return (v == MAX_FIELD) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control/status bundle between the button/switch front end and the stopwatch controller.
interface stopwatch_ctrl_if;
  logic       pause_pulse;
  logic       clear_pulse;
  logic       adjust;
  logic       select;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       blink;

  // Front end / stimulus side: drives buttons and switches, observes the display inputs.
  modport master (
    output pause_pulse, clear_pulse, adjust, select,
    input  minutes, seconds, running, blink
  );

  // Controller side.
  modport slave (
    input  pause_pulse, clear_pulse, adjust, select,
    output minutes, seconds, running, blink
  );
endinterface

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Clock-enable prescaler: counts 0..DIV-1 while enabled, pulses tick on the terminal count.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Next count: clear wins, otherwise advance and wrap while enabled, else hold phase.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch timekeeping controller: RUN/PAUSED/ADJUST sequencing, MM:SS registers, blink.
module stopwatch_ctrl #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 1,
  parameter int ADJ_HZ   = 2,
  parameter int BLINK_HZ = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_ctrl_if.slave  bus
);
  import stopwatch_pkg::*;

  state_e     state_q, state_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       running_q, running_d;
  logic       blink_q, blink_d;
  logic       adj_entry;
  logic       run_tick, adj_tick, blink_tick;

  // Run prescaler keeps its phase across pause; restarts on clear or when adjusting begins.
  tick_gen #(.DIV(CLK_HZ / TICK_HZ)) u_run_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == ST_RUN),
    .clr  (bus.clear_pulse || adj_entry),
    .tick (run_tick)
  );

  // Adjust prescaler restarts on entry so the first step lands one full period later.
  tick_gen #(.DIV(CLK_HZ / ADJ_HZ)) u_adj_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == ST_ADJUST),
    .clr  (adj_entry),
    .tick (adj_tick)
  );

  // Blink prescaler is free-running; each tick is one half period of the square wave.
  tick_gen #(.DIV(CLK_HZ / (2 * BLINK_HZ))) u_blink_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (1'b1),
    .clr  (1'b0),
    .tick (blink_tick)
  );

  // Next state: adjust switch overrides the pause button; pause is ignored while adjusting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PAUSED: begin
        if (bus.adjust)           state_d = ST_ADJUST;
        else if (bus.pause_pulse) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.adjust)           state_d = ST_ADJUST;
        else if (bus.pause_pulse) state_d = ST_PAUSED;
      end
      ST_ADJUST: begin
        if (!bus.adjust)          state_d = ST_PAUSED;
      end
      default:                    state_d = ST_PAUSED;
    endcase
    adj_entry = (state_q != ST_ADJUST) && (state_d == ST_ADJUST);
    running_d = (state_d == ST_RUN);
  end

  // Next MM:SS: clear beats any coincident tick; adjust steps one field with no carry.
  always_comb begin
    min_d   = min_q;
    sec_d   = sec_q;
    blink_d = blink_tick ? ~blink_q : blink_q;
    if (bus.clear_pulse) begin
      min_d = 6'd0;
      sec_d = 6'd0;
    end else if (state_q == ST_RUN && run_tick) begin
      sec_d = inc_field(sec_q);
      if (sec_q == MAX_FIELD) min_d = inc_field(min_q);
    end else if (state_q == ST_ADJUST && adj_tick) begin
      if (bus.select) sec_d = inc_field(sec_q);
      else            min_d = inc_field(min_q);
    end
  end

  // State, time and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PAUSED;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      running_q <= 1'b0;
      blink_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      running_q <= running_d;
      blink_q   <= blink_d;
    end
  end

  assign bus.minutes = min_q;
  assign bus.seconds = sec_q;
  assign bus.running = running_q;
  assign bus.blink   = blink_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a cycle-stamped expectation queue and a
// negedge monitor that compares the display outputs whenever an entry falls due.
module tb_stopwatch_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  stopwatch_ctrl_if bus();

  stopwatch_ctrl #(
    .CLK_HZ  (20),
    .TICK_HZ (1),
    .ADJ_HZ  (2),
    .BLINK_HZ(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int         at;
    string      name;
    logic [5:0] mm;
    logic [5:0] ss;
    logic       run;
    logic       chk_blink;
    logic       blk;
  } exp_t;

  exp_t exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to stamp when each expectation falls due.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: on the falling edge, pop and compare every expectation due this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      total = total + 1;
      if (e.at < cyc) begin
        bad = bad + 1;
        $display("FAIL %s: checked late at cycle %0d, required cycle %0d", e.name, cyc, e.at);
      end else if (bus.minutes !== e.mm || bus.seconds !== e.ss || bus.running !== e.run ||
                   (e.chk_blink && bus.blink !== e.blk)) begin
        bad = bad + 1;
        $display("FAIL %s: got %0d:%0d run=%b blink=%b, required %0d:%0d run=%b blink=%s",
                 e.name, bus.minutes, bus.seconds, bus.running, bus.blink,
                 e.mm, e.ss, e.run, e.chk_blink ? (e.blk ? "1" : "0") : "x");
      end else begin
        $display("check %s ok at cycle %0d: %0d:%0d run=%b", e.name, cyc, e.mm, e.ss, e.run);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int at, input string name, input int mm, input int ss,
                           input logic run, input logic chk_blink, input logic blk);
    exp_t e;
    e.at = at;
    e.name = name;
    e.mm = 6'(mm);
    e.ss = 6'(ss);
    e.run = run;
    e.chk_blink = chk_blink;
    e.blk = blk;
    exp_q.push_back(e);
  endtask

  task automatic expect_now(input string name, input int mm, input int ss, input logic run);
    expect_at(cyc, name, mm, ss, run, 1'b0, 1'b0);
  endtask

  task automatic pulse_pause();
    bus.pause_pulse = 1'b1;
    @(posedge clk);
    #1;
    bus.pause_pulse = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_pulse = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_pulse = 1'b0;
  endtask

  initial begin
    int c0;
    cyc = 0;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.pause_pulse = 1'b0;
    bus.clear_pulse = 1'b0;
    bus.adjust = 1'b0;
    bus.select = 1'b0;

    // 1. Reset values, then idle with a 4-cycle blink period.
    wait_cycles(3);
    expect_at(cyc, "reset_state", 0, 0, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      expect_at(c0 + k, $sformatf("blink_k%0d", k), 0, 0, 1'b0, 1'b1, ((k / 2) % 2) == 0);
    end
    wait_cycles(100);
    expect_now("idle_100", 0, 0, 1'b0);

    // 2. Run 61 seconds, then pause and hold.
    pulse_pause();
    expect_now("run_start", 0, 0, 1'b1);
    wait_cycles(20 * 61 - 1);
    expect_now("run_before_61", 1, 0, 1'b1);
    wait_cycles(1);
    expect_now("run_61s", 1, 1, 1'b1);
    pulse_pause();
    wait_cycles(200);
    expect_now("paused_hold", 1, 1, 1'b0);

    // 3. Clear, preload 59:58 via adjust (select switched mid-adjust), run across wrap.
    pulse_clear();
    expect_now("clear_paused", 0, 0, 1'b0);
    bus.adjust = 1'b1;
    bus.select = 1'b0;
    wait_cycles(1 + 590);
    expect_now("adj_min_59", 59, 0, 1'b0);
    bus.select = 1'b1;
    wait_cycles(580);
    expect_now("adj_preload", 59, 58, 1'b0);
    bus.adjust = 1'b0;
    wait_cycles(1);
    expect_now("adj_exit", 59, 58, 1'b0);
    pulse_pause();
    wait_cycles(20);
    expect_now("run_59_59", 59, 59, 1'b1);
    wait_cycles(20);
    expect_now("run_wrap_00_00", 0, 0, 1'b1);

    // 4. Adjust seconds 58 -> 59 -> 00 with no carry into minutes.
    pulse_pause();
    expect_now("pause_again", 0, 0, 1'b0);
    bus.adjust = 1'b1;
    bus.select = 1'b1;
    wait_cycles(581);
    expect_now("adj_sec_58", 0, 58, 1'b0);
    wait_cycles(9);
    expect_now("adj_sec_58_hold", 0, 58, 1'b0);
    wait_cycles(1);
    expect_now("adj_sec_59", 0, 59, 1'b0);
    wait_cycles(10);
    expect_now("adj_sec_wrap", 0, 0, 1'b0);
    bus.adjust = 1'b0;
    wait_cycles(1);
    expect_now("adj_to_paused", 0, 0, 1'b0);

    // 5. Clear coincident with the run tick at 00:09 wins and keeps RUN.
    pulse_pause();
    wait_cycles(180);
    expect_now("run_00_09", 0, 9, 1'b1);
    wait_cycles(19);
    expect_now("run_00_09_last", 0, 9, 1'b1);
    pulse_clear();
    expect_now("clear_beats_tick", 0, 0, 1'b1);
    wait_cycles(19);
    expect_now("after_clear_hold", 0, 0, 1'b1);
    wait_cycles(1);
    expect_now("after_clear_tick", 0, 1, 1'b1);

    // 6. Adjust beats pause in the same cycle; pause ignored in ADJUST; async reset.
    bus.adjust = 1'b1;
    bus.select = 1'b1;
    pulse_pause();
    expect_now("adj_over_pause", 0, 1, 1'b0);
    pulse_pause();
    wait_cycles(8);
    expect_now("adj_first_hold", 0, 1, 1'b0);
    wait_cycles(1);
    expect_now("adj_first_step", 0, 2, 1'b0);
    wait_cycles(5);
    rst_n = 1'b0;
    bus.adjust = 1'b0;
    expect_at(cyc, "async_reset", 0, 0, 1'b0, 1'b1, 1'b1);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(30);
    expect_now("post_reset_paused", 0, 0, 1'b0);
    pulse_pause();
    wait_cycles(19);
    expect_now("post_reset_hold", 0, 0, 1'b1);
    wait_cycles(1);
    expect_now("post_reset_tick", 0, 1, 1'b1);

    wait_cycles(2);
    if (exp_q.size() != 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
